// File: rtl/merge8_rr_if.sv
// Flit and select channels of the two-into-one round-robin merge.
interface merge8_rr_if #(
  parameter int W = 9
);
  logic         in0_valid;
  logic [W-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [W-1:0] in1_data;
  logic         in1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         s_valid;
  logic         s_data;
  logic         s_ready;

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready, s_ready,
    output in0_ready, in1_ready, out_valid, out_data, s_valid, s_data
  );

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready, s_ready,
    input  in0_ready, in1_ready, out_valid, out_data, s_valid, s_data
  );
endinterface

// File: rtl/merge8_rr.sv
// Round-robin merge of two flit channels into one, with a 2-entry queue that
// lets the data and select consumers stall independently.
module merge8_rr #(
  parameter int W = 9
) (
  input logic        clk,
  input logic        reset,
  merge8_rr_if.slave bus
);
  logic [W:0]   mem [2];
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  logic         prio;
  logic         data_done;
  logic         sel_done;

  logic         space;
  logic         grant0;
  logic         grant1;
  logic         push;
  logic         head_valid;
  logic         data_fin;
  logic         sel_fin;
  logic         retire;
  logic [W-1:0] push_data;

  always_comb begin
    space      = (count < 2'd2) && !reset;
    grant0     = space && bus.in0_valid && (!bus.in1_valid || !prio);
    grant1     = space && bus.in1_valid && (!bus.in0_valid || prio);
    push       = grant0 || grant1;
    push_data  = grant1 ? bus.in1_data : bus.in0_data;

    head_valid = (count != 2'd0);
    // A head retires once both consumers have taken it, in either order.
    data_fin   = data_done || (head_valid && !data_done && bus.out_ready);
    sel_fin    = sel_done  || (head_valid && !sel_done  && bus.s_ready);
    retire     = head_valid && data_fin && sel_fin;

    bus.in0_ready = grant0;
    bus.in1_ready = grant1;
    bus.out_valid = head_valid && !data_done;
    bus.s_valid   = head_valid && !sel_done;
    bus.out_data  = mem[rd_ptr][W-1:0];
    bus.s_data    = mem[rd_ptr][W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      count     <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      prio      <= 1'b0;
      data_done <= 1'b0;
      sel_done  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {grant1, push_data};
        wr_ptr      <= ~wr_ptr;
        prio        <= ~grant1;
      end
      if (retire) begin
        rd_ptr    <= ~rd_ptr;
        data_done <= 1'b0;
        sel_done  <= 1'b0;
      end else begin
        data_done <= data_fin;
        sel_done  <= sel_fin;
      end
      if (push && !retire)
        count <= count + 2'd1;
      else if (retire && !push)
        count <= count - 2'd1;
    end
  end
endmodule

// File: tb/tb_merge8_rr.sv
// Directed bench for merge8_rr: expected flits/selects queued at acceptance,
// popped and compared by an independent output monitor.
module tb_merge8_rr;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  merge8_rr_if #(.W(W)) bus ();
  merge8_rr #(.W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_d[$];
  logic         exp_s[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic expect_flit(input logic sel, input logic [W-1:0] d);
    exp_d.push_back(d);
    exp_s.push_back(sel);
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_d.size() == 0) chk("data_unexpected", 32'(bus.out_data), 32'h1ff_ffff);
        else                   chk("data_order", 32'(bus.out_data), 32'(exp_d.pop_front()));
      end
      if (bus.s_valid && bus.s_ready) begin
        if (exp_s.size() == 0) chk("sel_unexpected", 32'(bus.s_data), 32'h1ff_ffff);
        else                   chk("sel_order", 32'(bus.s_data), 32'(exp_s.pop_front()));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in0_data  = 9'h011;
    bus.in1_valid = 1'b1;
    bus.in1_data  = 9'h122;
    bus.out_ready = 1'b0;
    bus.s_ready   = 1'b0;

    // Reset: no ready even with offers pending, then idle
    smp(); chk("rst_rdy0", 32'(bus.in0_ready), 0); chk("rst_rdy1", 32'(bus.in1_ready), 0);
    nxt();
    smp(); chk("rst_rdy0b", 32'(bus.in0_ready), 0); chk("rst_ovalid", 32'(bus.out_valid), 0);
    nxt();
    reset = 1'b0; bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("idle_ovalid", 32'(bus.out_valid), 0);
      chk("idle_svalid", 32'(bus.s_valid), 0);
      chk("idle_rdy0", 32'(bus.in0_ready), 0);
      chk("idle_rdy1", 32'(bus.in1_ready), 0);
      chk("idle_odata", 32'(bus.out_data), 0);
      chk("idle_sdata", 32'(bus.s_data), 0);
      nxt();
    end

    // Simultaneous offer: In0 first after reset, In1 next
    bus.in0_valid = 1'b1; bus.in0_data = 9'h0A5;
    bus.in1_valid = 1'b1; bus.in1_data = 9'h1F3;
    bus.out_ready = 1'b1; bus.s_ready = 1'b1;
    smp();
    chk("t2_rdy0", 32'(bus.in0_ready), 1); chk("t2_rdy1", 32'(bus.in1_ready), 0);
    chk("t2_nobypass", 32'(bus.out_valid), 0);
    expect_flit(1'b0, 9'h0A5);
    nxt(); bus.in0_valid = 1'b0;
    smp();
    chk("t2_rdy1b", 32'(bus.in1_ready), 1);
    chk("t2_lat_valid", 32'(bus.out_valid), 1); chk("t2_lat_data", 32'(bus.out_data), 9'h0A5);
    chk("t2_lat_sel", 32'(bus.s_data), 0);
    expect_flit(1'b1, 9'h1F3);
    nxt(); bus.in1_valid = 1'b0;
    smp();
    chk("t2_second", 32'(bus.out_data), 9'h1F3); chk("t2_second_sel", 32'(bus.s_data), 1);
    nxt();
    smp(); chk("t2_empty_o", 32'(bus.out_valid), 0); chk("t2_empty_s", 32'(bus.s_valid), 0);
    nxt();

    // Continuous contention: grants alternate starting with In0
    for (int k = 0; k < 8; k++) begin
      bus.in0_valid = 1'b1; bus.in0_data = W'(32'h020 + k);
      bus.in1_valid = 1'b1; bus.in1_data = W'(32'h120 + k);
      smp();
      chk("rr_rdy0", 32'(bus.in0_ready), (k % 2 == 0) ? 1 : 0);
      chk("rr_rdy1", 32'(bus.in1_ready), (k % 2 == 1) ? 1 : 0);
      chk("rr_ovalid", 32'(bus.out_valid), (k > 0) ? 1 : 0);
      if (k % 2 == 0) expect_flit(1'b0, W'(32'h020 + k));
      else            expect_flit(1'b1, W'(32'h120 + k));
      nxt();
    end
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    smp(); nxt();

    // Data consumer stalled, select consumer ready: fill, then drain
    bus.out_ready = 1'b0; bus.s_ready = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_data = 9'h033;
    smp(); chk("st_rdy_c0", 32'(bus.in0_ready), 1); expect_flit(1'b0, 9'h033);
    nxt(); bus.in0_data = 9'h044;
    smp(); chk("st_rdy_c1", 32'(bus.in0_ready), 1);
    chk("st_svalid_c1", 32'(bus.s_valid), 1); chk("st_sdata_c1", 32'(bus.s_data), 0);
    expect_flit(1'b0, 9'h044);
    nxt(); bus.in0_data = 9'h055;
    smp(); chk("st_full_rdy0", 32'(bus.in0_ready), 0); chk("st_full_rdy1", 32'(bus.in1_ready), 0);
    chk("st_hold_valid", 32'(bus.out_valid), 1); chk("st_hold_data", 32'(bus.out_data), 9'h033);
    chk("st_sel_taken", 32'(bus.s_valid), 0);
    nxt();
    smp(); chk("st_full_c3", 32'(bus.in0_ready), 0);
    nxt(); bus.out_ready = 1'b1;
    smp(); chk("st_full_retire", 32'(bus.in0_ready), 0);
    nxt();
    smp(); chk("st_resume", 32'(bus.in0_ready), 1); chk("st_drain_b", 32'(bus.out_data), 9'h044);
    expect_flit(1'b0, 9'h055);
    nxt(); bus.in0_valid = 1'b0;
    smp(); chk("st_drain_c", 32'(bus.out_data), 9'h055);
    nxt();
    smp(); chk("st_empty", 32'(bus.out_valid), 0);
    nxt();

    // In1 alone back-to-back; prio returns to In0 afterwards
    for (int k = 0; k < 4; k++) begin
      bus.in1_valid = 1'b1; bus.in1_data = W'(32'h1A0 + k);
      smp();
      chk("solo_rdy1", 32'(bus.in1_ready), 1); chk("solo_rdy0", 32'(bus.in0_ready), 0);
      expect_flit(1'b1, W'(32'h1A0 + k));
      nxt();
    end
    bus.in0_valid = 1'b1; bus.in0_data = 9'h0BB; bus.in1_data = 9'h1BB;
    smp();
    chk("solo_prio_rdy0", 32'(bus.in0_ready), 1); chk("solo_prio_rdy1", 32'(bus.in1_ready), 0);
    expect_flit(1'b0, 9'h0BB);
    nxt(); bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    smp(); nxt();

    // Fill with both sinks stalled, then reset: queued flits must vanish
    bus.out_ready = 1'b0; bus.s_ready = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = 9'h0DE;
    smp(); chk("rf_rdy_c0", 32'(bus.in0_ready), 1);
    nxt(); bus.in0_data = 9'h0EF;
    smp(); chk("rf_rdy_c1", 32'(bus.in0_ready), 1);
    nxt(); reset = 1'b1;
    smp(); chk("rf_rst_rdy0", 32'(bus.in0_ready), 0); chk("rf_rst_rdy1", 32'(bus.in1_ready), 0);
    nxt(); reset = 1'b0; bus.in0_valid = 1'b0; bus.out_ready = 1'b1; bus.s_ready = 1'b1;
    smp();
    chk("rf_ovalid", 32'(bus.out_valid), 0); chk("rf_svalid", 32'(bus.s_valid), 0);
    chk("rf_odata", 32'(bus.out_data), 0); chk("rf_sdata", 32'(bus.s_data), 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp(); chk("rf_gone", 32'(bus.out_valid), 0);
    end

    chk("left_data", 32'(exp_d.size()), 0);
    chk("left_sel", 32'(exp_s.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
